// File: rtl/node_cfg_loader_pkg.sv
// ---------------------------------------------------------------------------
// node_cfg_pkg
// Shared definitions for the boot-time configuration loader:
//   - state_t      : loader FSM states
//   - page_t       : one 8-byte EEPROM configuration page (byte 0 in [0])
//   - OFS_*        : byte offsets inside the page
//   - DEF_*        : default magic byte and receiver node IDs
//   - page_xor()   : XOR of all eight page bytes (zero on a consistent page)
// ---------------------------------------------------------------------------
package node_cfg_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_REQ,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_RETRY_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int PAGE_BYTES = 8;

  typedef logic [PAGE_BYTES-1:0][7:0] page_t;

  localparam logic [2:0] OFS_NODE_ID = 3'd0;
  localparam logic [2:0] OFS_MAGIC   = 3'd1;
  localparam logic [2:0] OFS_FLAGS   = 3'd2;
  localparam logic [2:0] OFS_CSUM    = 3'd7;

  localparam logic [7:0] DEF_CFG_MAGIC     = 8'hA5;
  localparam logic [7:0] DEF_RECEIVER_ID_1 = 8'd2;
  localparam logic [7:0] DEF_RECEIVER_ID_2 = 8'd3;

  // The checksum byte is chosen so that this reduction is zero.
  function automatic logic [7:0] page_xor(input page_t p);
    return p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5] ^ p[6] ^ p[7];
  endfunction

endpackage

// File: rtl/node_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// node_cfg_loader_if
// Handshake between the configuration loader and the EEPROM page reader.
//   start : one-cycle read request from the loader
//   busy  : reader cannot accept a request
//   done  : one-cycle completion pulse; page is valid in that cycle
//   page  : the eight bytes read from the EEPROM
// master = loader side, slave = reader side.
// ---------------------------------------------------------------------------
interface node_cfg_loader_if;

  logic               start;
  logic               busy;
  logic               done;
  node_cfg_pkg::page_t page;

  modport master (output start, input busy, input done, input page);
  modport slave  (input start, output busy, output done, output page);

endinterface

// File: rtl/node_cfg_loader_page_check.sv
// ---------------------------------------------------------------------------
// cfg_page_check
// Combinational validation of a captured configuration page.
//   page    : eight shadow bytes (byte 0 in page[0])
//   page_ok : magic byte matches CFG_MAGIC and the XOR of all bytes is zero
// ---------------------------------------------------------------------------
module cfg_page_check
  import node_cfg_pkg::*;
#(
  parameter logic [7:0] CFG_MAGIC = DEF_CFG_MAGIC
) (
  input  page_t page,
  output logic  page_ok
);

  assign page_ok = (page[OFS_MAGIC] == CFG_MAGIC) && (page_xor(page) == 8'h00);

endmodule

// File: rtl/node_cfg_loader.sv
// ---------------------------------------------------------------------------
// node_cfg_loader
// Boot-time configuration sequencer. After a power-up settle delay it asks
// the EEPROM reader for one page, waits for it with a timeout, validates it
// and publishes node ID / flags / receiver role. Failed attempts are retried
// after an idle gap until MAX_ATTEMPTS is reached.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_reload       : re-run the load (honoured only in DONE or FAIL)
//   eeprom         : request/response handshake to the page reader
//   o_node_id      : validated page byte 0
//   o_flags        : validated page byte 2
//   o_is_receiver  : node ID is one of the two receiver IDs
//   o_cfg_valid    : configuration outputs are valid
//   o_cfg_error    : all attempts failed
//   o_loading      : high while the loader is not in DONE or FAIL
//   o_attempts     : failed attempts so far
// ---------------------------------------------------------------------------
module node_cfg_loader
  import node_cfg_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES = 10000000,
  parameter int unsigned TIMEOUT_CYCLES   = 2000000,
  parameter int unsigned RETRY_GAP_CYCLES = 200000,
  parameter int unsigned MAX_ATTEMPTS     = 3,
  parameter logic [7:0]  CFG_MAGIC        = DEF_CFG_MAGIC,
  parameter logic [7:0]  RECEIVER_ID_1    = DEF_RECEIVER_ID_1,
  parameter logic [7:0]  RECEIVER_ID_2    = DEF_RECEIVER_ID_2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reload,
  node_cfg_loader_if.master eeprom,
  output logic [7:0]        o_node_id,
  output logic [7:0]        o_flags,
  output logic              o_is_receiver,
  output logic              o_cfg_valid,
  output logic              o_cfg_error,
  output logic              o_loading,
  output logic [3:0]        o_attempts
);

  localparam logic [31:0] INIT_LAST     = 32'(INIT_WAIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST      = 32'(RETRY_GAP_CYCLES - 1);
  localparam logic [3:0]  ATTEMPT_LIMIT = 4'(MAX_ATTEMPTS);

  state_t      state;
  state_t      state_d;
  // Wait, timeout and gap intervals never overlap, so one counter serves all
  // three; it restarts from zero on every state change.
  logic [31:0] cnt;
  page_t       shadow;
  logic        timed_out;
  logic        start_q;
  logic        page_ok;
  logic [3:0]  attempts_inc;

  logic        start_d;
  logic        latch_page;
  logic        timeout_hit;
  logic        attempt_pass;
  logic        attempt_fail;
  logic        reload_hit;

  cfg_page_check #(
    .CFG_MAGIC (CFG_MAGIC)
  ) u_page_check (
    .page    (shadow),
    .page_ok (page_ok)
  );

  assign attempts_inc = o_attempts + 4'd1;
  assign eeprom.start = start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT_WAIT;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state;
    start_d      = 1'b0;
    latch_page   = 1'b0;
    timeout_hit  = 1'b0;
    attempt_pass = 1'b0;
    attempt_fail = 1'b0;
    reload_hit   = 1'b0;
    case (state)
      ST_INIT_WAIT: begin
        if (cnt == INIT_LAST) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!eeprom.busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion in the timeout cycle still counts as a completion.
        if (eeprom.done) begin
          latch_page = 1'b1;
          state_d    = ST_CHECK;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (page_ok && !timed_out) begin
          attempt_pass = 1'b1;
          state_d      = ST_DONE;
        end else begin
          attempt_fail = 1'b1;
          state_d      = (attempts_inc == ATTEMPT_LIMIT) ? ST_FAIL : ST_RETRY_GAP;
        end
      end
      ST_RETRY_GAP: begin
        if (cnt == GAP_LAST) state_d = ST_REQ;
      end
      ST_DONE, ST_FAIL: begin
        if (i_reload) begin
          reload_hit = 1'b1;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      // NOTE: the page shadow is only eight bytes of flops, not a RAM, so it
      // is cleared with everything else and never exposes stale data.
      shadow        <= '0;
      timed_out     <= 1'b0;
      start_q       <= 1'b0;
      o_node_id     <= '0;
      o_flags       <= '0;
      o_is_receiver <= 1'b0;
      o_cfg_valid   <= 1'b0;
      o_cfg_error   <= 1'b0;
      o_loading     <= 1'b0;
      o_attempts    <= '0;
    end else begin
      cnt       <= (state_d != state) ? '0 : cnt + 32'd1;
      start_q   <= start_d;
      // Registered from the next state so it is 0 while reset is held.
      o_loading <= !(state_d inside {ST_DONE, ST_FAIL});

      if (latch_page) begin
        shadow    <= eeprom.page;
        timed_out <= 1'b0;
      end
      if (timeout_hit) timed_out <= 1'b1;

      if (attempt_pass) begin
        o_node_id     <= shadow[OFS_NODE_ID];
        o_flags       <= shadow[OFS_FLAGS];
        o_is_receiver <= (shadow[OFS_NODE_ID] == RECEIVER_ID_1) ||
                         (shadow[OFS_NODE_ID] == RECEIVER_ID_2);
        o_cfg_valid   <= 1'b1;
        o_cfg_error   <= 1'b0;
      end
      if (attempt_fail) begin
        o_attempts <= attempts_inc;
        if (attempts_inc == ATTEMPT_LIMIT) o_cfg_error <= 1'b1;
      end
      // Node ID, flags and role deliberately survive a reload.
      if (reload_hit) begin
        o_cfg_valid <= 1'b0;
        o_cfg_error <= 1'b0;
        o_attempts  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_node_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_node_cfg_loader
// Self-checking bench for node_cfg_loader with short timing parameters.
// A stimulus process plans each load as a list of reader responses and pushes
// the expected outcome into a queue; a reader model answers start pulses from
// the plan; a monitor pops expectations whenever a load completes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_node_cfg_loader;
  import node_cfg_pkg::*;

  localparam int INIT_W = 16;
  localparam int TMO    = 64;
  localparam int GAP    = 8;
  localparam int MAXA   = 3;

  // arrive: cycles from the start edge to the edge sampling done; 0 = never.
  typedef struct {
    page_t page;
    int    arrive;
  } attempt_t;

  typedef struct {
    logic       valid;
    logic       error;
    logic [7:0] node_id;
    logic [7:0] flags;
    logic       is_rx;
    logic [3:0] attempts;
    int         starts;
  } expect_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload;
  logic [7:0] node_id;
  logic [7:0] flags;
  logic       is_rx;
  logic       valid;
  logic       err;
  logic       loading;
  logic [3:0] attempts;

  node_cfg_loader_if eeprom_if ();

  node_cfg_loader #(
    .INIT_WAIT_CYCLES (INIT_W),
    .TIMEOUT_CYCLES   (TMO),
    .RETRY_GAP_CYCLES (GAP),
    .MAX_ATTEMPTS     (MAXA)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_reload      (reload),
    .eeprom        (eeprom_if),
    .o_node_id     (node_id),
    .o_flags       (flags),
    .o_is_receiver (is_rx),
    .o_cfg_valid   (valid),
    .o_cfg_error   (err),
    .o_loading     (loading),
    .o_attempts    (attempts)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cyc = 0;

  attempt_t plan_q[$];
  expect_t  exp_q[$];

  logic [7:0] m_node  = 8'h00;
  logic [7:0] m_flags = 8'h00;
  logic       m_rx    = 1'b0;

  // Edge count since reset release: the first edge with reset low is 1.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic page_t mk_page(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b7);
    page_t p = '0;
    p[0] = b0;
    p[1] = b1;
    p[2] = b2;
    p[7] = b7;
    return p;
  endfunction

  function automatic attempt_t att(input page_t p, input int arrive);
    attempt_t t;
    t.page   = p;
    t.arrive = arrive;
    return t;
  endfunction

  function automatic bit page_good(input page_t p);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 8; i++) x ^= p[i];
    return (p[1] == 8'hA5) && (x == 8'h00);
  endfunction

  function automatic attempt_t rand_attempt();
    attempt_t   t;
    page_t      p;
    logic [7:0] x = 8'h00;
    int         kind = $urandom_range(0, 5);
    for (int i = 0; i < 8; i++) p[i] = 8'($urandom);
    p[0] = 8'($urandom_range(0, 7));
    p[1] = (kind == 2) ? (8'hA5 ^ 8'($urandom_range(1, 255))) : 8'hA5;
    for (int i = 0; i < 7; i++) x ^= p[i];
    p[7] = (kind == 3) ? (x ^ 8'($urandom_range(1, 255))) : x;
    t.page   = p;
    t.arrive = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(1, TMO);
    if (kind == 4) t.arrive = 0;
    if (kind == 5) t.arrive = $urandom_range(TMO + 1, TMO + 8);
    return t;
  endfunction

  // Reference model: attempts are consumed in order until one arrives in time
  // with a good page, or the attempt budget is spent.
  task automatic issue_load(input attempt_t a [MAXA]);
    expect_t e;
    int      fails = 0;
    bit      ok = 1'b0;
    for (int i = 0; i < MAXA && !ok; i++) begin
      plan_q.push_back(a[i]);
      if (a[i].arrive >= 1 && a[i].arrive <= TMO && page_good(a[i].page)) begin
        ok      = 1'b1;
        m_node  = a[i].page[0];
        m_flags = a[i].page[2];
        m_rx    = (m_node == 8'd2) || (m_node == 8'd3);
      end else begin
        fails++;
      end
    end
    e.valid    = ok;
    e.error    = !ok;
    e.node_id  = m_node;
    e.flags    = m_flags;
    e.is_rx    = m_rx;
    e.attempts = 4'(fails);
    e.starts   = fails + (ok ? 1 : 0);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_node_id", node_id, 0);
    check("rst_flags", flags, 0);
    check("rst_is_receiver", is_rx, 0);
    check("rst_cfg_valid", valid, 0);
    check("rst_cfg_error", err, 0);
    check("rst_loading", loading, 0);
    check("rst_attempts", attempts, 0);
    check("rst_start", eeprom_if.start, 0);
  endtask

  task automatic wait_start(output int c);
    int n = 0;
    while (!eeprom_if.start && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", eeprom_if.start, 1);
    c = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (loading && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("load_finishes", loading, 0);
  endtask

  // Called at a negedge; reload is sampled by the following posedge.
  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // EEPROM reader model: answers each start pulse from the plan queue.
  initial begin
    attempt_t p;
    eeprom_if.done = 1'b0;
    eeprom_if.page = '0;
    forever begin
      @(negedge clk);
      if (!reset && eeprom_if.start) begin
        check("plan_available", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) begin
          p = plan_q.pop_front();
          if (p.arrive > 0) begin
            repeat (p.arrive - 1) @(negedge clk);
            eeprom_if.page = p.page;
            eeprom_if.done = 1'b1;
            done_cyc       = cyc + 1;
            @(negedge clk);
            eeprom_if.done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compares each completed load against the scoreboard.
  initial begin
    expect_t e;
    int      starts;
    int      last_start;
    bit      prev_loading;
    bit      prev_valid;
    starts       = 0;
    last_start   = 0;
    prev_loading = 1'b0;
    prev_valid   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        starts       = 0;
        prev_loading = 1'b0;
        prev_valid   = 1'b0;
      end else begin
        if (eeprom_if.start) begin
          if (starts > 0) check("start_spacing", (cyc - last_start) >= GAP + 1, 1);
          starts++;
          last_start = cyc;
        end
        if (valid && !prev_valid) check("valid_latency", cyc, done_cyc + 1);
        if (prev_loading && !loading) begin
          check("expectation_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cfg_valid", valid, e.valid);
            check("cfg_error", err, e.error);
            check("node_id", node_id, e.node_id);
            check("flags", flags, e.flags);
            check("is_receiver", is_rx, e.is_rx);
            check("attempts", attempts, e.attempts);
            check("start_pulses", starts, e.starts);
          end
          starts = 0;
        end
        prev_loading = loading;
        prev_valid   = valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    attempt_t a [MAXA];
    int       c;
    int       s;
    reset          = 1'b1;
    reload         = 1'b0;
    eeprom_if.busy = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs();

    // Power-up load of a good page.
    a[0] = att(mk_page(8'h02, 8'hA5, 8'h01, 8'hA6), 5);
    a[1] = a[0];
    a[2] = a[0];
    issue_load(a);
    reset = 1'b0;
    wait_start(c);
    check("start_cycle_after_reset", c, INIT_W + 1);
    wait_idle(2000);
    repeat (10) @(negedge clk);

    // Two bad checksums, then a good non-receiver page.
    a[0] = att(mk_page(8'h02, 8'hA5, 8'h01, 8'h00), $urandom_range(1, 10));
    a[1] = att(mk_page(8'h02, 8'hA5, 8'h01, 8'h00), $urandom_range(1, 10));
    a[2] = att(mk_page(8'h07, 8'hA5, 8'h01, 8'hA3), 4);
    issue_load(a);
    pulse_reload();
    wait_idle(2000);
    repeat (10) @(negedge clk);

    // Reader never answers: three timeouts.
    a[0] = att(mk_page(8'h00, 8'h00, 8'h00, 8'h00), 0);
    a[1] = a[0];
    a[2] = a[0];
    issue_load(a);
    pulse_reload();
    wait_idle(2000);
    check("fail_error_flag", err, 1);
    repeat (10) @(negedge clk);

    // Busy held in REQ, then completion in the timeout cycle.
    eeprom_if.busy = 1'b1;
    a[0] = att(mk_page(8'h03, 8'hA5, 8'h80, 8'h26), TMO);
    a[1] = a[0];
    a[2] = a[0];
    issue_load(a);
    pulse_reload();
    s = 0;
    repeat (20) begin
      @(negedge clk);
      if (eeprom_if.start) s++;
    end
    check("start_while_busy", s, 0);
    eeprom_if.busy = 1'b0;
    wait_idle(2000);
    repeat (10) @(negedge clk);

    // Reset while waiting for the page; the late done must be ignored.
    plan_q.push_back(att(mk_page(8'h55, 8'hA5, 8'h00, 8'hF0), 8));
    pulse_reload();
    wait_start(c);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    m_node  = 8'h00;
    m_flags = 8'h00;
    m_rx    = 1'b0;
    a[0] = att(mk_page(8'h02, 8'hA5, 8'h01, 8'hA6), $urandom_range(1, 10));
    a[1] = a[0];
    a[2] = a[0];
    issue_load(a);
    reset = 1'b0;
    wait_start(c);
    check("start_cycle_after_mid_reset", c, INIT_W + 1);
    wait_idle(2000);
    repeat (10) @(negedge clk);

    // Wrong magic three times from DONE: valid drops at once, node ID kept.
    for (int i = 0; i < MAXA; i++) a[i] = att(mk_page(8'h02, 8'h00, 8'h01, 8'h03), $urandom_range(1, 20));
    issue_load(a);
    pulse_reload();
    check("valid_drops_on_reload", valid, 0);
    check("attempts_clear_on_reload", attempts, 0);
    wait_idle(2000);
    repeat (10) @(negedge clk);

    // Randomized loads.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < MAXA; i++) a[i] = rand_attempt();
      issue_load(a);
      pulse_reload();
      wait_idle(2000);
      repeat (10) @(negedge clk);
    end

    check("plan_queue_drained", plan_q.size(), 0);
    check("expect_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
